// File: rtl/armleocpu_plic_claim_ctrl_pkg.sv
// Shared types and sizing for the PLIC claim/complete controller.
// Source ID k (1..N) maps to bit k-1 of the per-source vectors; ID 0 means "no interrupt".
package armleocpu_plic_claim_ctrl_pkg;

    localparam int CONTEXT_COUNT          = 4;
    localparam int INTERRUPT_SOURCE_COUNT = 32;
    localparam int IDW                    = $clog2(INTERRUPT_SOURCE_COUNT + 1);
    localparam int CTXW                   = (CONTEXT_COUNT > 1) ? $clog2(CONTEXT_COUNT) : 1;

    typedef logic [IDW-1:0]  irq_id_t;
    typedef logic [CTXW-1:0] ctx_idx_t;

    localparam irq_id_t ID_NONE = '0;

    typedef enum logic [1:0] {
        GW_IDLE      = 2'd0,
        GW_PENDING   = 2'd1,
        GW_INSERVICE = 2'd2
    } gw_state_e;

    // Position of context idx in round-robin order starting at ptr (0 = first served).
    function automatic int rr_distance(input int idx, input int ptr);
        return (idx >= ptr) ? (idx - ptr) : (idx + CONTEXT_COUNT - ptr);
    endfunction

    function automatic ctx_idx_t rr_next(input int idx);
        return (idx == CONTEXT_COUNT - 1) ? ctx_idx_t'(0) : ctx_idx_t'(idx + 1);
    endfunction

endpackage

// File: rtl/armleocpu_plic_claim_ctrl_if.sv
// Claim/complete bus between the register frontend / priority matrix and the claim controller.
interface armleocpu_plic_claim_ctrl_if;
    import armleocpu_plic_claim_ctrl_pkg::*;

    logic [CONTEXT_COUNT-1:0][IDW-1:0] ctx_best_id;
    logic [CONTEXT_COUNT-1:0]          context_irq_pending;
    logic [CONTEXT_COUNT-1:0]          claim_req;
    logic [CONTEXT_COUNT-1:0]          claim_valid;
    logic [CONTEXT_COUNT-1:0][IDW-1:0] claim_id;
    logic [CONTEXT_COUNT-1:0]          complete_req;
    logic [CONTEXT_COUNT-1:0][IDW-1:0] complete_id;
    logic [CONTEXT_COUNT-1:0]          complete_err;

    modport master (
        output ctx_best_id, claim_req, complete_req, complete_id,
        input  context_irq_pending, claim_valid, claim_id, complete_err
    );

    modport slave (
        input  ctx_best_id, claim_req, complete_req, complete_id,
        output context_irq_pending, claim_valid, claim_id, complete_err
    );

endinterface

// File: rtl/armleocpu_plic_gateway.sv
// Per-source level gateway: latches a request until claimed, then blocks it until completed.
//   state        | meaning
//   GW_IDLE      | no request latched; irq sampled every cycle
//   GW_PENDING   | request latched, visible to the priority matrix
//   GW_INSERVICE | claimed by a context, waiting for its complete
module armleocpu_plic_gateway
    import armleocpu_plic_claim_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic pending,
    output logic in_service
);

    gw_state_e state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= GW_IDLE;
            pending    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            case (state)
                GW_IDLE: begin
                    if (irq) begin
                        state   <= GW_PENDING;
                        pending <= 1'b1;
                    end
                end
                GW_PENDING: begin
                    if (claim_hit) begin
                        state      <= GW_INSERVICE;
                        pending    <= 1'b0;
                        in_service <= 1'b1;
                    end
                end
                GW_INSERVICE: begin
                    // irq is not looked at here; a still-high line re-pends from IDLE next cycle
                    if (complete_hit) begin
                        state      <= GW_IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= GW_IDLE;
                    pending    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/armleocpu_plic_claim_ctrl.sv
// PLIC claim/complete sequencer: per-source gateways, same-ID claim arbitration (round-robin),
// owner tracking of in-service sources and complete validation.
module armleocpu_plic_claim_ctrl
    import armleocpu_plic_claim_ctrl_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [INTERRUPT_SOURCE_COUNT-1:0] irq_in,
    output logic [INTERRUPT_SOURCE_COUNT-1:0] irq_pending,
    armleocpu_plic_claim_ctrl_if.slave        bus
);

    localparam int N = INTERRUPT_SOURCE_COUNT;
    localparam int C = CONTEXT_COUNT;

    logic [N-1:0]           src_in_service;
    logic [N-1:0]           claim_hit;
    logic [N-1:0]           complete_hit;
    logic [N-1:0][CTXW-1:0] owner;

    logic [C-1:0] claim_cand;
    logic [C-1:0] claim_win;
    logic [C-1:0] claim_contended;
    logic [C-1:0] complete_ok;
    ctx_idx_t     rr_ptr;
    ctx_idx_t     rr_ptr_nxt;
    logic         ptr_found;

    for (genvar k = 0; k < N; k++) begin : g_gateway
        armleocpu_plic_gateway u_gateway (
            .clk          (clk),
            .rst_n        (rst_n),
            .irq          (irq_in[k]),
            .claim_hit    (claim_hit[k]),
            .complete_hit (complete_hit[k]),
            .pending      (irq_pending[k]),
            .in_service   (src_in_service[k])
        );
    end

    // A claim is only a candidate if its best ID still names a PENDING source;
    // stale IDs (already in service or dropped) simply return 0.
    always_comb begin
        claim_cand = '0;
        for (int c = 0; c < C; c++) begin
            for (int k = 0; k < N; k++) begin
                if (bus.claim_req[c] && (bus.ctx_best_id[c] == IDW'(k + 1)) && irq_pending[k]) begin
                    claim_cand[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        claim_win       = claim_cand;
        claim_contended = '0;
        for (int c = 0; c < C; c++) begin
            for (int d = 0; d < C; d++) begin
                if ((d != c) && claim_cand[c] && claim_cand[d]
                        && (bus.ctx_best_id[d] == bus.ctx_best_id[c])) begin
                    claim_contended[c] = 1'b1;
                    if (rr_distance(d, int'(rr_ptr)) < rr_distance(c, int'(rr_ptr))) begin
                        claim_win[c] = 1'b0;
                    end
                end
            end
        end
    end

    // With several contended groups in one cycle the lowest-numbered winner moves the pointer.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        ptr_found  = 1'b0;
        for (int c = 0; c < C; c++) begin
            if (claim_win[c] && claim_contended[c] && !ptr_found) begin
                rr_ptr_nxt = rr_next(c);
                ptr_found  = 1'b1;
            end
        end
    end

    always_comb begin
        claim_hit = '0;
        for (int c = 0; c < C; c++) begin
            for (int k = 0; k < N; k++) begin
                if (claim_win[c] && (bus.ctx_best_id[c] == IDW'(k + 1))) begin
                    claim_hit[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        complete_ok  = '0;
        complete_hit = '0;
        for (int c = 0; c < C; c++) begin
            for (int k = 0; k < N; k++) begin
                if (bus.complete_req[c] && (bus.complete_id[c] == IDW'(k + 1))
                        && src_in_service[k] && (owner[k] == CTXW'(c))) begin
                    complete_ok[c]  = 1'b1;
                    complete_hit[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr                  <= '0;
            owner                   <= '0;
            bus.claim_valid         <= '0;
            bus.claim_id            <= '0;
            bus.complete_err        <= '0;
            bus.context_irq_pending <= '0;
        end else begin
            rr_ptr           <= rr_ptr_nxt;
            bus.claim_valid  <= bus.claim_req;
            bus.complete_err <= bus.complete_req & ~complete_ok;
            for (int c = 0; c < C; c++) begin
                bus.claim_id[c]            <= claim_win[c] ? bus.ctx_best_id[c] : ID_NONE;
                bus.context_irq_pending[c] <= (bus.ctx_best_id[c] != ID_NONE);
            end
            for (int k = 0; k < N; k++) begin
                for (int c = 0; c < C; c++) begin
                    if (claim_win[c] && (bus.ctx_best_id[c] == IDW'(k + 1))) begin
                        owner[k] <= CTXW'(c);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_armleocpu_plic_claim_ctrl.sv
// Scenario bench for the PLIC claim controller; claim and complete_err pulses are scoreboarded.
module tb_armleocpu_plic_claim_ctrl;
    import armleocpu_plic_claim_ctrl_pkg::*;

    typedef struct {
        int      ctx;
        irq_id_t id;
    } exp_claim_t;

    logic                              clk;
    logic                              rst_n;
    logic [INTERRUPT_SOURCE_COUNT-1:0] irq_in;
    logic [INTERRUPT_SOURCE_COUNT-1:0] irq_pending;

    armleocpu_plic_claim_ctrl_if bus ();

    armleocpu_plic_claim_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .irq_pending (irq_pending),
        .bus         (bus)
    );

    int         checks = 0;
    int         passed = 0;
    exp_claim_t claim_q[$];
    int         err_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        for (int c = 0; c < CONTEXT_COUNT; c++) begin
            if (bus.claim_valid[c] === 1'b1) begin
                checks++;
                if (claim_q.size() == 0) begin
                    $display("FAIL claim_unexpected: ctx=%0d id=%0d, required no pulse", c, bus.claim_id[c]);
                end else begin
                    exp_claim_t e;
                    e = claim_q.pop_front();
                    if (e.ctx !== c || e.id !== bus.claim_id[c])
                        $display("FAIL claim_pulse: got ctx=%0d id=%0d, required ctx=%0d id=%0d",
                                 c, bus.claim_id[c], e.ctx, e.id);
                    else passed++;
                end
            end
            if (bus.complete_err[c] === 1'b1) begin
                checks++;
                if (err_q.size() == 0) begin
                    $display("FAIL err_unexpected: complete_err ctx=%0d, required no pulse", c);
                end else begin
                    int e;
                    e = err_q.pop_front();
                    if (e !== c) $display("FAIL err_pulse: got ctx=%0d, required ctx=%0d", c, e);
                    else passed++;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.claim_req    = '0;
        bus.complete_req = '0;
        bus.complete_id  = '0;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        irq_in          = '0;
        bus.ctx_best_id = '0;
        idle_inputs();
        repeat (3) tick();
        checks++; if (irq_pending !== '0) $display("FAIL reset_pending: got %h required 0", irq_pending); else passed++;
        checks++; if (bus.claim_valid !== '0 || bus.claim_id !== '0)
            $display("FAIL reset_claim: valid=%b id=%h required 0", bus.claim_valid, bus.claim_id); else passed++;
        checks++; if (bus.complete_err !== '0 || bus.context_irq_pending !== '0)
            $display("FAIL reset_misc: err=%b ctxp=%b required 0", bus.complete_err, bus.context_irq_pending); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_gateway_latch();
        irq_in[4] = 1'b1;
        tick();
        irq_in[4] = 1'b0;
        checks++; if (irq_pending !== 32'h10) $display("FAIL latch_rise: got %h required 00000010", irq_pending); else passed++;
        repeat (3) tick();
        checks++; if (irq_pending !== 32'h10) $display("FAIL latch_hold: got %h required 00000010", irq_pending); else passed++;
    endtask

    task automatic test_context_pending();
        bus.ctx_best_id[2] = 6'd7;
        tick();
        checks++; if (bus.context_irq_pending !== 4'b0100)
            $display("FAIL ctx_pending_set: got %b required 0100", bus.context_irq_pending); else passed++;
        bus.ctx_best_id[2] = 6'd0;
        tick();
        checks++; if (bus.context_irq_pending !== 4'b0000)
            $display("FAIL ctx_pending_clr: got %b required 0000", bus.context_irq_pending); else passed++;
    endtask

    task automatic test_claim_complete();
        irq_in[4]          = 1'b1;
        bus.ctx_best_id[0] = 6'd5;
        bus.claim_req      = 4'b0001;
        claim_q.push_back('{0, 6'd5});
        tick();
        bus.claim_req = '0;
        checks++; if (bus.claim_valid !== 4'b0001) $display("FAIL claim_timing: got %b required 0001", bus.claim_valid); else passed++;
        checks++; if (irq_pending[4] !== 1'b0) $display("FAIL claim_clears_pending: got %b required 0", irq_pending[4]); else passed++;
        tick();
        checks++; if (irq_pending[4] !== 1'b0) $display("FAIL inservice_ignores_irq: got %b required 0", irq_pending[4]); else passed++;
        bus.complete_req   = 4'b0001;
        bus.complete_id[0] = 6'd5;
        tick();
        idle_inputs();
        checks++; if (irq_pending[4] !== 1'b0) $display("FAIL complete_idle_cycle: got %b required 0", irq_pending[4]); else passed++;
        tick();
        checks++; if (irq_pending[4] !== 1'b1) $display("FAIL complete_repend: got %b required 1", irq_pending[4]); else passed++;
    endtask

    task automatic test_arbitration();
        bus.ctx_best_id[0] = 6'd5;
        bus.ctx_best_id[1] = 6'd5;
        bus.claim_req      = 4'b0011;
        claim_q.push_back('{0, 6'd5});
        claim_q.push_back('{1, 6'd0});
        tick();
        bus.claim_req = '0;
        checks++; if (bus.claim_valid !== 4'b0011) $display("FAIL arb1_valid: got %b required 0011", bus.claim_valid); else passed++;
        bus.complete_req   = 4'b0001;
        bus.complete_id[0] = 6'd5;
        tick();
        idle_inputs();
        tick();
        checks++; if (irq_pending[4] !== 1'b1) $display("FAIL arb_repend: got %b required 1", irq_pending[4]); else passed++;
        bus.claim_req = 4'b0011;
        claim_q.push_back('{0, 6'd0});
        claim_q.push_back('{1, 6'd5});
        tick();
        bus.claim_req = '0;
        irq_in[4]     = 1'b0;
        checks++; if (irq_pending[4] !== 1'b0) $display("FAIL arb2_claimed: got %b required 0", irq_pending[4]); else passed++;
        tick();
        #1;
        checks++; if (claim_q.size() != 0) $display("FAIL arb_missing_pulses: got %0d left required 0", claim_q.size()); else passed++;
    endtask

    task automatic test_complete_err();
        bus.ctx_best_id  = '0;
        bus.complete_req = 4'b0001;
        bus.complete_id[0] = 6'd5;
        err_q.push_back(0);
        tick();
        checks++; if (bus.complete_err !== 4'b0001) $display("FAIL err_wrong_owner: got %b required 0001", bus.complete_err); else passed++;
        bus.complete_id[0] = 6'd0;
        err_q.push_back(0);
        tick();
        bus.complete_id[0] = 6'd33;
        err_q.push_back(0);
        tick();
        bus.complete_id[0] = 6'd7;
        err_q.push_back(0);
        tick();
        bus.complete_req   = 4'b0010;
        bus.complete_id[0] = 6'd0;
        bus.complete_id[1] = 6'd5;
        tick();
        idle_inputs();
        checks++; if (bus.complete_err !== 4'b0000) $display("FAIL owner_complete_err: got %b required 0000", bus.complete_err); else passed++;
        tick();
        #1;
        checks++; if (err_q.size() != 0) $display("FAIL err_missing_pulses: got %0d left required 0", err_q.size()); else passed++;
        checks++; if (irq_pending !== '0) $display("FAIL after_complete_idle: got %h required 0", irq_pending); else passed++;
    endtask

    task automatic test_back_to_back();
        irq_in[9:8] = 2'b11;
        tick();
        irq_in[9:8] = 2'b00;
        bus.ctx_best_id[2] = 6'd9;
        bus.claim_req      = 4'b0100;
        claim_q.push_back('{2, 6'd9});
        tick();
        claim_q.push_back('{2, 6'd0});
        tick();
        bus.ctx_best_id[2] = 6'd10;
        bus.complete_req   = 4'b0100;
        bus.complete_id[2] = 6'd9;
        claim_q.push_back('{2, 6'd10});
        tick();
        idle_inputs();
        checks++; if (irq_pending[9:8] !== 2'b00) $display("FAIL b2b_pending: got %b required 00", irq_pending[9:8]); else passed++;
        checks++; if (bus.complete_err !== 4'b0000) $display("FAIL b2b_complete_err: got %b required 0000", bus.complete_err); else passed++;
        bus.complete_req   = 4'b0100;
        bus.complete_id[2] = 6'd10;
        tick();
        idle_inputs();
        bus.ctx_best_id = '0;
        tick();
        #1;
        checks++; if (claim_q.size() != 0) $display("FAIL b2b_missing_pulses: got %0d left required 0", claim_q.size()); else passed++;
    endtask

    task automatic test_no_best();
        irq_in[0] = 1'b1;
        tick();
        irq_in[0]          = 1'b0;
        bus.ctx_best_id[3] = 6'd0;
        bus.claim_req      = 4'b1000;
        claim_q.push_back('{3, 6'd0});
        tick();
        bus.claim_req = '0;
        checks++; if (bus.claim_valid !== 4'b1000) $display("FAIL nobest_valid: got %b required 1000", bus.claim_valid); else passed++;
        checks++; if (irq_pending !== 32'h1) $display("FAIL nobest_pending: got %h required 00000001", irq_pending); else passed++;
    endtask

    task automatic test_reset_mid();
        irq_in[2] = 1'b1;
        tick();
        irq_in[2]          = 1'b0;
        bus.ctx_best_id[0] = 6'd3;
        bus.claim_req      = 4'b0001;
        claim_q.push_back('{0, 6'd3});
        tick();
        rst_n              = 1'b0;
        bus.ctx_best_id[1] = 6'd1;
        bus.claim_req      = 4'b0010;
        tick();
        checks++; if (irq_pending !== '0 || bus.context_irq_pending !== '0)
            $display("FAIL midreset_pending: irq=%h ctx=%b required 0", irq_pending, bus.context_irq_pending); else passed++;
        checks++; if (bus.claim_valid !== '0 || bus.claim_id !== '0 || bus.complete_err !== '0)
            $display("FAIL midreset_pulses: valid=%b id=%h err=%b required 0", bus.claim_valid, bus.claim_id, bus.complete_err); else passed++;
        rst_n           = 1'b1;
        idle_inputs();
        bus.ctx_best_id = '0;
        irq_in[2]       = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        checks++; if (irq_pending !== 32'h4) $display("FAIL postreset_pending: got %h required 00000004", irq_pending); else passed++;
        bus.ctx_best_id[1] = 6'd3;
        bus.ctx_best_id[3] = 6'd3;
        bus.claim_req      = 4'b1010;
        claim_q.push_back('{1, 6'd3});
        claim_q.push_back('{3, 6'd0});
        tick();
        idle_inputs();
        bus.ctx_best_id = '0;
        tick();
        #1;
        checks++; if (claim_q.size() != 0) $display("FAIL postreset_missing_pulses: got %0d left required 0", claim_q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_gateway_latch();
        test_context_pending();
        test_claim_complete();
        test_arbitration();
        test_complete_err();
        test_back_to_back();
        test_no_best();
        test_reset_mid();
        repeat (2) tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
